// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle controller: FSM states, opcode
// classes, opcode constants and ALU operation codes.
package multicycle_control_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_ADD,
    CLS_SUB,
    CLS_AND,
    CLS_ORR,
    CLS_LDUR,
    CLS_STUR,
    CLS_CBZ
  } opClass_t;

  localparam logic [10:0] OP_ADD    = 11'b10001011000;
  localparam logic [10:0] OP_SUB    = 11'b11001011000;
  localparam logic [10:0] OP_AND    = 11'b10001010000;
  localparam logic [10:0] OP_ORR    = 11'b10101010000;
  localparam logic [10:0] OP_LDUR   = 11'b11111000010;
  localparam logic [10:0] OP_STUR   = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ_HI = 8'b10110100;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  function automatic opClass_t classify(input logic [10:0] op);
    opClass_t c;
    c = CLS_NONE;
    if (op == OP_ADD)              c = CLS_ADD;
    else if (op == OP_SUB)         c = CLS_SUB;
    else if (op == OP_AND)         c = CLS_AND;
    else if (op == OP_ORR)         c = CLS_ORR;
    else if (op == OP_LDUR)        c = CLS_LDUR;
    else if (op == OP_STUR)        c = CLS_STUR;
    else if (op[10:3] == OP_CBZ_HI) c = CLS_CBZ;
    return c;
  endfunction

  function automatic logic [3:0] aluCtlOf(input opClass_t c);
    logic [3:0] a;
    case (c)
      CLS_SUB: a = ALU_SUB;
      CLS_AND: a = ALU_AND;
      CLS_ORR: a = ALU_ORR;
      CLS_CBZ: a = ALU_PASSB;
      CLS_ADD, CLS_LDUR, CLS_STUR: a = ALU_ADD;
      default: a = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath signal bundle; the datapath drives Op and status,
// the controller drives the control strobes and observability outputs.
interface multicycle_control_if #(
  parameter int RETIRED_W = 32
);
  logic [10:0]          Op;
  logic                 zero_T;
  logic                 mem_ready;
  logic                 IRWrite;
  logic                 PCWrite;
  logic                 PCSrc;
  logic                 AluSrc;
  logic [3:0]           AluControl;
  logic                 Reg2Loc;
  logic                 regWrite;
  logic                 memRead;
  logic                 memWrite;
  logic                 memtoReg;
  logic                 exc;
  logic [2:0]           state;
  logic [RETIRED_W-1:0] retired;

  modport master (
    output Op, zero_T, mem_ready,
    input  IRWrite, PCWrite, PCSrc, AluSrc, AluControl, Reg2Loc,
           regWrite, memRead, memWrite, memtoReg, exc, state, retired
  );

  modport slave (
    input  Op, zero_T, mem_ready,
    output IRWrite, PCWrite, PCSrc, AluSrc, AluControl, Reg2Loc,
           regWrite, memRead, memWrite, memtoReg, exc, state, retired
  );
endinterface

// File: rtl/multicycle_control_opcode_decoder.sv
// Combinational opcode classifier: maps the 11-bit Op field to an
// instruction class and its ALU operation.
module opcode_decoder
  import multicycle_control_pkg::*;
(
  input  logic [10:0] Op,
  output opClass_t    opClass,
  output logic [3:0]  aluCtl
);
  always_comb begin
    opClass = classify(Op);
    aluCtl  = aluCtlOf(opClass);
  end
endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/HALT) with a
// sticky unsupported-opcode flag and a retired-instruction counter.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int RETIRED_W = 32
) (
  input logic            clk,
  input logic            reset,
  multicycle_control_if.slave bus
);
  state_t               stateQ, stateD;
  opClass_t             clsQ, decCls;
  logic [3:0]           aluQ, decAlu;
  logic                 excQ;
  logic [RETIRED_W-1:0] retiredQ;

  logic irWrite, pcWrite, pcSrc, aluSrc, reg2Loc;
  logic regWrite, memRead, memWrite, memtoReg;
  logic [3:0] aluControl;

  opcode_decoder uDecoder (
    .Op      (bus.Op),
    .opClass (decCls),
    .aluCtl  (decAlu)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ   <= FETCH;
      clsQ     <= CLS_NONE;
      aluQ     <= '0;
      excQ     <= 1'b0;
      retiredQ <= '0;
    end else begin
      stateQ <= stateD;
      // Class is captured once so ALU controls stay stable for the instruction.
      if (stateQ == DECODE) begin
        clsQ <= decCls;
        aluQ <= decAlu;
      end
      if (stateD == HALT) excQ <= 1'b1;
      if (pcWrite) retiredQ <= retiredQ + RETIRED_W'(1);
    end
  end

  always_comb begin
    stateD     = stateQ;
    irWrite    = 1'b0;
    pcWrite    = 1'b0;
    pcSrc      = 1'b0;
    aluSrc     = 1'b0;
    reg2Loc    = 1'b0;
    aluControl = '0;
    regWrite   = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    memtoReg   = 1'b0;

    if (stateQ == EXECUTE || stateQ == MEMORY || stateQ == WRITEBACK) begin
      aluControl = aluQ;
      aluSrc     = (clsQ == CLS_LDUR) || (clsQ == CLS_STUR);
      reg2Loc    = (clsQ == CLS_STUR) || (clsQ == CLS_CBZ);
    end

    case (stateQ)
      FETCH: begin
        irWrite = 1'b1;
        stateD  = DECODE;
      end
      DECODE: stateD = (decCls == CLS_NONE) ? HALT : EXECUTE;
      EXECUTE: begin
        case (clsQ)
          CLS_ADD, CLS_SUB, CLS_AND, CLS_ORR: stateD = WRITEBACK;
          CLS_LDUR, CLS_STUR:                 stateD = MEMORY;
          CLS_CBZ: begin
            pcWrite = 1'b1;
            pcSrc   = bus.zero_T;
            stateD  = FETCH;
          end
          default: stateD = HALT;
        endcase
      end
      MEMORY: begin
        if (clsQ == CLS_LDUR) begin
          memRead = 1'b1;
          if (bus.mem_ready) stateD = WRITEBACK;
        end else if (clsQ == CLS_STUR) begin
          memWrite = 1'b1;
          if (bus.mem_ready) begin
            pcWrite = 1'b1;
            stateD  = FETCH;
          end
        end else begin
          stateD = HALT;
        end
      end
      WRITEBACK: begin
        regWrite = 1'b1;
        memtoReg = (clsQ == CLS_LDUR);
        pcWrite  = 1'b1;
        stateD   = FETCH;
      end
      HALT:    stateD = HALT;
      default: stateD = FETCH;
    endcase
  end

  assign bus.IRWrite    = irWrite;
  assign bus.PCWrite    = pcWrite;
  assign bus.PCSrc      = pcSrc;
  assign bus.AluSrc     = aluSrc;
  assign bus.AluControl = aluControl;
  assign bus.Reg2Loc    = reg2Loc;
  assign bus.regWrite   = regWrite;
  assign bus.memRead    = memRead;
  assign bus.memWrite   = memWrite;
  assign bus.memtoReg   = memtoReg;
  assign bus.exc        = excQ;
  assign bus.state      = stateQ;
  assign bus.retired    = retiredQ;
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expectations are queued
// from an instruction-level model and compared as the DUT steps.
module tb_multicycle_control;
  localparam int RW = 3;

  logic clk;
  logic reset;
  multicycle_control_if #(.RETIRED_W(RW)) bus ();

  multicycle_control #(.RETIRED_W(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] op;
    logic        zero;
    logic        memReady;
    logic [2:0]  st;
    logic [7:0]  strb;   // {IRWrite,PCWrite,PCSrc,regWrite,memRead,memWrite,memtoReg,exc}
    logic        chkAlu;
    logic [5:0]  aluv;   // {AluSrc,Reg2Loc,AluControl}
    int          ret;
  } rec_t;

  rec_t q[$];
  int total = 0;
  int bad   = 0;
  int modelRet = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] mk(input logic ir, pw, ps, rw, mr, mw, mt, ex);
    return {ir, pw, ps, rw, mr, mw, mt, ex};
  endfunction

  // Model classes: 0 bad, 1 ADD, 2 SUB, 3 AND, 4 ORR, 5 LDUR, 6 STUR, 7 CBZ
  function automatic int tbClass(input logic [10:0] op);
    casez (op)
      11'b10001011000: return 1;
      11'b11001011000: return 2;
      11'b10001010000: return 3;
      11'b10101010000: return 4;
      11'b11111000010: return 5;
      11'b11111000000: return 6;
      11'b10110100???: return 7;
      default:         return 0;
    endcase
  endfunction

  function automatic logic [3:0] tbAlu(input int c);
    case (c)
      2: return 4'b0110;
      3: return 4'b0000;
      4: return 4'b0001;
      7: return 4'b0111;
      default: return 4'b0010;
    endcase
  endfunction

  task automatic push(input logic [10:0] op, input logic zero, input logic mr,
                      input logic [2:0] st, input logic [7:0] strb,
                      input logic chk, input logic [5:0] aluv);
    rec_t r;
    r.op = op; r.zero = zero; r.memReady = mr; r.st = st; r.strb = strb;
    r.chkAlu = chk; r.aluv = aluv; r.ret = modelRet;
    q.push_back(r);
    if (strb[6]) modelRet++;
  endtask

  task automatic genInstr(input logic [10:0] op, input logic zero, input int waits);
    int c;
    logic [5:0] av;
    c = tbClass(op);
    push(op, zero, 1'($urandom), 3'd0, mk(1,0,0,0,0,0,0,0), 0, '0);
    push(op, zero, 1'($urandom), 3'd1, mk(0,0,0,0,0,0,0,0), 0, '0);
    if (c == 0) begin
      for (int i = 0; i < 20; i++)
        push(op, 1'($urandom), 1'($urandom), 3'd5, mk(0,0,0,0,0,0,0,1), 0, '0);
      return;
    end
    av = {(c == 5 || c == 6), (c == 6 || c == 7), tbAlu(c)};
    if (c == 7)
      push(op, zero, 1'($urandom), 3'd2, mk(0,1,zero,0,0,0,0,0), 1, av);
    else
      push(op, zero, 1'($urandom), 3'd2, mk(0,0,0,0,0,0,0,0), 1, av);
    if (c == 5 || c == 6) begin
      for (int w = 0; w <= waits; w++) begin
        logic last;
        last = (w == waits);
        push(op, zero, last, 3'd3,
             mk(0, (c == 6) && last, 0, 0, c == 5, c == 6, 0, 0), 1, av);
      end
    end
    if (c >= 1 && c <= 5)
      push(op, zero, 1'($urandom), 3'd4, mk(0,1,0,1,0,0,c == 5,0), 1, av);
  endtask

  task automatic runQueue(input int n);
    rec_t r;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      r = q.pop_front();
      bus.Op = r.op;
      bus.zero_T = r.zero;
      bus.mem_ready = r.memReady;
      @(negedge clk);
      checkVal("state", 32'(bus.state), 32'(r.st));
      checkVal("strobes", 32'({bus.IRWrite, bus.PCWrite, bus.PCSrc, bus.regWrite,
                               bus.memRead, bus.memWrite, bus.memtoReg, bus.exc}), 32'(r.strb));
      checkVal("retired", 32'(bus.retired), 32'(r.ret % (1 << RW)));
      if (r.chkAlu)
        checkVal("aluCtrl", 32'({bus.AluSrc, bus.Reg2Loc, bus.AluControl}), 32'(r.aluv));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    #2;
    reset = 1'b0;
    #1;
    checkVal("rstState", 32'(bus.state), 32'd0);
    checkVal("rstExc", 32'(bus.exc), 32'd0);
    checkVal("rstIRWrite", 32'(bus.IRWrite), 32'd1);
    checkVal("rstPCWrite", 32'(bus.PCWrite), 32'd0);
    checkVal("rstRegWrite", 32'(bus.regWrite), 32'd0);
    checkVal("rstRetired", 32'(bus.retired), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    modelRet = 0;
    q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus.Op = '0;
    bus.zero_T = 1'b0;
    bus.mem_ready = 1'b0;
    #3;
    checkVal("initState", 32'(bus.state), 32'd0);
    checkVal("initStrobes", 32'({bus.IRWrite, bus.PCWrite, bus.PCSrc, bus.regWrite,
                                 bus.memRead, bus.memWrite, bus.memtoReg, bus.exc}), 32'h80);
    checkVal("initRetired", 32'(bus.retired), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Eleven retiring instructions: the 3-bit counter wraps along the way.
    genInstr(11'b10001011000, 1'b0, 0);
    genInstr(11'b11111000010, 1'b0, 2);
    genInstr(11'b10110100101, 1'b1, 0);
    genInstr(11'b10110100000, 1'b0, 0);
    genInstr(11'b11111000000, 1'b1, 0);
    genInstr(11'b11001011000, 1'b0, 0);
    genInstr(11'b10001010000, 1'b1, 0);
    genInstr(11'b10101010000, 1'b0, 0);
    genInstr(11'b11111000010, 1'b1, 0);
    genInstr(11'b11111000000, 1'b0, 1);
    genInstr(11'b10110100111, 1'b1, 0);
    runQueue(q.size());

    // Reset while LDUR is waiting in MEMORY.
    genInstr(11'b11111000010, 1'b0, 3);
    runQueue(5);
    checkVal("memWaitState", 32'(bus.state), 32'd3);
    doReset();

    // Unsupported opcode: HALT is absorbing, then reset recovers.
    genInstr(11'b00000000000, 1'b0, 0);
    runQueue(q.size());
    doReset();

    genInstr(11'b10001011000, 1'b0, 0);
    runQueue(q.size());
    checkVal("retiredAfterAdd", 32'(bus.retired), 32'd1);
    checkVal("fetchAfterAdd", 32'(bus.state), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
